fifo_reader: RTL
================

# fifo_reader

Read-side master for the 8-deep FIFO. On a start command it drains a requested number of words, issuing single-cycle `rd_en` pulses only when the FIFO is non-empty. Each word is captured on `rd_ack` and presented to a downstream consumer over a valid/ready handshake. It sits between the FIFO read port and any block that consumes buffered data, and is the counterpart of the FIFO's write-side producer.

## Interface
- `DATA_WIDTH`, 32: FIFO word width.
- `LEN_WIDTH`, 4: width of burst length and remaining counter.
- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin burst; sampled only in IDLE.
- `len` in LEN_WIDTH: words to read, latched with `start`; 0 = empty burst.
- `abort` in 1: synchronous cancel, any state -> IDLE next cycle.
- `empty` in 1: FIFO empty flag.
- `rd_ack` in 1: FIFO read accepted; `d_out` valid this cycle.
- `rd_err` in 1: FIFO read rejected (underflow).
- `d_out` in DATA_WIDTH: FIFO read data.
- `rd_en` out 1: FIFO read request, one-cycle pulse.
- `m_data` out DATA_WIDTH: word to consumer, registered.
- `m_valid` out 1: `m_data` valid.
- `m_ready` in 1: consumer accepts when `m_valid && m_ready`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at burst end.
- `err` out 1: sticky burst error, cleared on next accepted `start`.

## Operation
- Reset: state IDLE; `rd_en`, `m_valid`, `busy`, `done`, `err` = 0; `m_data` = 0; remaining = 0.
- Outputs `rd_en`, `busy` and `done` are Moore, decoded from state. `m_valid` and `m_data` are registers.
- States are 3-bit binary: IDLE 000, READ 001, ISSUE 010, WAIT 011, HOLD 100, DONE 101.
- IDLE:
  - `start=1` latches `len` into remaining and clears `err`.
  - Then -> READ if `len!=0`, else -> DONE.
- READ: `empty=0` -> ISSUE; `empty=1` -> stay, with no request issued.
- ISSUE: `rd_en=1` for exactly this cycle; -> WAIT unconditionally.
- WAIT:
  - `rd_ack=1`: load `m_data<=d_out`, set `m_valid`, remaining-1, -> HOLD.
  - `rd_err=1`, or neither response: set `err`, -> DONE. A missing response is a timeout.
  - `rd_ack` and `rd_err` both high: `rd_err` wins.
- HOLD: on `m_valid && m_ready`, clear `m_valid`; then -> DONE if remaining==0, else -> READ.
- DONE: `done=1` for one cycle; -> IDLE.
- `abort` overrides all transitions:
  - Next state is IDLE; `m_valid` is cleared.
  - No `done` pulse; `err` is unchanged.
  - An in-flight `rd_ack` arriving in the abort cycle is discarded.
- `start` outside IDLE is ignored. `len` is not re-sampled mid-burst.
- remaining never underflows; it decrements only on `rd_ack` in WAIT.

## Timing
- Request-to-data: `rd_en` high in cycle t, FIFO responds in t+1, `m_valid` high from t+2.
- Minimum cost per word is 4 cycles (READ, ISSUE, WAIT, HOLD) with `m_ready` held high.
- Burst of N words: `done` rises no earlier than cycle 1+4N after the `start` cycle.
- `len=0`: `done` in the cycle after `start`.
- Empty-burst transition: `busy` is 1 in DONE and 0 from the following cycle.
- Consumer side: `m_data` is stable while `m_valid=1 && m_ready=0`; back-pressure holds the block in HOLD indefinitely.
- Reset mid-burst: all outputs return to reset values immediately (asynchronous).

## Structure
- Shared package `fifo_rd_pkg`: the six state encodings and the `DATA_WIDTH`/`LEN_WIDTH` defaults.
- Sub-module `fifo_rd_ns`: purely combinational next-state logic over state, `start`, `len`, `abort`, `empty`, `rd_ack`, `rd_err`, `m_ready` and remaining==0.
- Top `fifo_reader` holds:
  - the state register;
  - the remaining counter;
  - the `m_data`/`m_valid` registers;
  - the `err` register;
  - the Moore output decode.

## Test plan
- FIFO preloaded with 0xA0..0xA2; `start`, `len=3`, `m_ready=1` -> three `rd_en` pulses; `m_data` = 0xA0, 0xA1, 0xA2; `done` at cycle 13; `err=0`.
- `empty=1` for 5 cycles after `start`, `len=1` -> no `rd_en` while empty; one read after `empty` falls; `done` follows.
- `len=2`, `m_ready` low for 6 cycles on the first word -> `m_data` stable; second `rd_en` only after the handshake.
- Response forced to `rd_err=1` in WAIT on word 1 of 4 -> `err=1`; `done` one cycle later; exactly one `rd_en` issued.
- `abort` in HOLD during a `len=4` burst -> IDLE next cycle; `m_valid=0`; no `done`.
- `reset_n` low mid-WAIT -> all outputs 0 immediately; a new `start` then runs normally.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// fifo_reader shared definitions.
// State encodings and default widths.
package fifo_rd_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 4;

  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_READ  = 3'b001;
  localparam logic [2:0] S_ISSUE = 3'b010;
  localparam logic [2:0] S_WAIT  = 3'b011;
  localparam logic [2:0] S_HOLD  = 3'b100;
  localparam logic [2:0] S_DONE  = 3'b101;

endpackage

// File: rtl/fifo_reader_if.sv
// fifo_reader bundle: command, FIFO read port,
// consumer handshake and status.
interface fifo_reader_if
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);
  logic                  start;
  logic [LEN_WIDTH-1:0]  len;
  logic                  abort;
  logic                  empty;
  logic                  rd_ack;
  logic                  rd_err;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    input  start, len, abort, empty,
    input  rd_ack, rd_err, d_out, m_ready,
    output rd_en, m_data, m_valid,
    output busy, done, err
  );

  modport slave (
    output start, len, abort, empty,
    output rd_ack, rd_err, d_out, m_ready,
    input  rd_en, m_data, m_valid,
    input  busy, done, err
  );
endinterface

// File: rtl/fifo_rd_ns.sv
// fifo_reader next-state logic.
// Purely combinational; abort beats everything.
module fifo_rd_ns
  import fifo_rd_pkg::*;
#(
  parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
  input  logic [2:0]           state,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 abort,
  input  logic                 empty,
  input  logic                 rd_ack,
  input  logic                 rd_err,
  input  logic                 m_valid,
  input  logic                 m_ready,
  input  logic                 rem_zero,
  output logic [2:0]           next_state
);

  logic len_zero;
  assign len_zero = (len == '0);

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = S_IDLE;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (start)
            next_state = len_zero ? S_DONE : S_READ;
        end
        (state == S_READ): begin
          if (!empty)
            next_state = S_ISSUE;
        end
        (state == S_ISSUE): next_state = S_WAIT;
        (state == S_WAIT): begin
          // rd_err wins; silence is a timeout
          if (rd_ack && !rd_err)
            next_state = S_HOLD;
          else
            next_state = S_DONE;
        end
        (state == S_HOLD): begin
          if (m_valid && m_ready)
            next_state = rem_zero ? S_DONE : S_READ;
        end
        (state == S_DONE): next_state = S_IDLE;
        default: next_state = S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Read-side burst master for the 8-deep FIFO.
// Drains len words, one rd_en pulse per word.
module fifo_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input logic         clk,
  input logic         reset_n,
  fifo_reader_if.master port
);

  logic [2:0]            state;
  logic [2:0]            next_state;
  logic [LEN_WIDTH-1:0]  rem;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  err_q;
  logic                  accept;
  logic                  take;
  logic                  fail;
  logic                  handoff;

  fifo_rd_ns #(
    .LEN_WIDTH (LEN_WIDTH)
  ) u_ns (
    .state      (state),
    .start      (port.start),
    .len        (port.len),
    .abort      (port.abort),
    .empty      (port.empty),
    .rd_ack     (port.rd_ack),
    .rd_err     (port.rd_err),
    .m_valid    (valid_q),
    .m_ready    (port.m_ready),
    .rem_zero   (rem == '0),
    .next_state (next_state)
  );

  assign accept = (state == S_IDLE) && port.start
                  && !port.abort;
  assign take = (state == S_WAIT) && port.rd_ack
                && !port.rd_err && !port.abort;
  assign fail = (state == S_WAIT) && !port.abort
                && (port.rd_err || !port.rd_ack);
  assign handoff = (state == S_HOLD) && valid_q
                   && port.m_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      rem     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept)
        rem <= port.len;
      else if (take && rem != '0)
        rem <= rem - LEN_WIDTH'(1);
      if (take)
        data_q <= port.d_out;
      // abort drops any word in flight
      if (port.abort)
        valid_q <= 1'b0;
      else if (take)
        valid_q <= 1'b1;
      else if (handoff)
        valid_q <= 1'b0;
      if (accept)
        err_q <= 1'b0;
      else if (fail)
        err_q <= 1'b1;
    end
  end

  assign port.rd_en   = (state == S_ISSUE);
  assign port.busy    = (state != S_IDLE);
  assign port.done    = (state == S_DONE);
  assign port.m_data  = data_q;
  assign port.m_valid = valid_q;
  assign port.err     = err_q;

endmodule
